sprite_pixel_fetch: RTL
=======================

// Module: sprite_pixel_fetch
// PURPOSE
//  Consumer side of the draw_* object interface (pixel_addr + isObject per object).
//  Per VGA pixel: picks the highest-priority hit object, reads the shared sprite ROM
//  (sync, 1-cycle latency), falls back to the background address on miss or
//  colour-key, then drives RGB and delayed syncs. Sits between draw_* modules and VGA pins.
// PARAMETERS
//  NUM_OBJ      4        object layers; index 0 = highest priority
//  ADDR_W       17       sprite ROM address width
//  RGB_W        12       ROM word, {R[11:8],G[7:4],B[3:0]}
//  ROM_DEPTH    86400    valid ROM words; addr >= ROM_DEPTH is forced to 0
//  TRANSPARENT  12'hF0F  colour key for object pixels
// PORTS
//  clk        in   1               system clock (100 MHz)
//  rst_n      in   1               async reset, active-low
//  pix_en     in   1               one-cycle pixel strobe, period >= 4 clk
//  valid      in   1               pixel in visible area (sampled on pix_en)
//  hsync_in   in   1               raw hsync (sampled on pix_en)
//  vsync_in   in   1               raw vsync (sampled on pix_en)
//  obj_hit    in   NUM_OBJ         isObject per layer
//  obj_addr   in   NUM_OBJ*ADDR_W  pixel_addr per layer; layer i at [i*ADDR_W +: ADDR_W]
//  bg_addr    in   ADDR_W          background ROM address
//  rom_addr   out  ADDR_W          sprite ROM address (combinational from state/latches)
//  rom_data   in   RGB_W           ROM data, valid the cycle after rom_addr
//  vga_r/g/b  out  4 each          pixel colour
//  hsync      out  1               hsync aligned to vga_*
//  vsync      out  1               vsync aligned to vga_*
//  overrun    out  1               sticky: pix_en arrived while FSM busy
// BEHAVIOUR
//  - Reset: state IDLE, vga_r/g/b=0, hsync=vsync=1, overrun=0, rom_addr=0, latches 0.
//  - IDLE + pix_en: latch valid, syncs, sel (lowest i with obj_hit[i]), hit_any,
//    obj_addr[sel], bg_addr; and present pix_nxt/syncs from previous pixel to outputs.
//  - FETCH (k+1): rom_addr = hit_any ? obj_addr_l : bg_addr_l. -> CHECK_OBJ.
//  - CHECK_OBJ (k+2): if !hit_any, or rom_data != TRANSPARENT: pix_nxt=rom_data -> IDLE.
//    Else rom_addr=bg_addr_l (same cycle) -> CHECK_BG.
//  - CHECK_BG (k+3): pix_nxt=rom_data -> IDLE.
//  - !valid latched: pix_nxt forced 0 regardless of ROM data; FSM sequence unchanged.
//  - Output latency exactly one pixel: values for pixel n appear on pix_en of pixel n+1;
//    vga_*/hsync/vsync change only in the cycle after a pix_en.
//  - Address >= ROM_DEPTH (object or bg) replaced by 0 before driving rom_addr.
//  - Multiple obj_hit bits: lowest index only; others ignored.
//  - pix_en while not IDLE: overrun<=1 (sticky to reset), abandon current pixel
//    (pix_nxt keeps old value), outputs still update, latch new pixel, go FETCH.
//  - rst_n low mid-pixel: immediate return to reset values; no partial output.
// CONFIGURATION
//  SPRITE_COLOR_KEY_EN defined: transparency test as above.
//  Not defined: CHECK_OBJ always final (object pixels opaque, TRANSPARENT unused);
//  CHECK_BG state unreachable and may be omitted; worst case 3 cycles per pixel.
// TESTING
//  1 No hit, valid=1, bg_addr=100, ROM[100]=12'h123 -> next pix_en: r/g/b=1/2/3, rom_addr seq 100.
//  2 obj_hit=4'b0110, addr1=200 (ROM=12'hABC), addr2=300 -> rom_addr 200, output 12'hABC.
//  3 Key EN: obj addr 50 ROM=12'hF0F, bg 60 ROM=12'h0F0 -> rom_addr 50 then 60, out 12'h0F0;
//    without EN -> out 12'hF0F, rom_addr never 60.
//  4 valid=0, ROM data 12'hFFF, hsync_in=0 -> out 0, hsync=0 one pixel later.
//  5 obj addr 86400 -> rom_addr 0; pix_en period 2 clk -> overrun=1 until rst_n low.
//  6 rst_n low during CHECK_OBJ -> outputs 0/syncs 1 immediately, IDLE after release.

Source files
------------

// File: rtl/sprite_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pixel_fetch
// Description : Per-pixel compositor between the draw_* object modules and the
//               VGA pins. For each pixel strobe it selects the highest-priority
//               object hit (index 0 wins), reads the shared synchronous sprite
//               ROM and falls back to the background address on a miss. It
//               also falls back when the object pixel equals the colour key.
//               The pixel is presented, with delayed syncs, on the next strobe.
//               Build option: define SPRITE_COLOR_KEY_EN to enable the
//               colour-key fallback. Without it, object pixels are opaque.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_pixel_fetch #(
    parameter int                NUM_OBJ     = 4,
    parameter int                ADDR_W      = 17,
    parameter int                RGB_W       = 12,
    parameter int                ROM_DEPTH   = 86400,
    parameter logic [RGB_W-1:0]  TRANSPARENT = 12'hF0F
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_pix_en,
    input  logic                      i_valid,
    input  logic                      i_hsync,
    input  logic                      i_vsync,
    input  logic [NUM_OBJ-1:0]        i_obj_hit,
    input  logic [NUM_OBJ*ADDR_W-1:0] i_obj_addr,
    input  logic [ADDR_W-1:0]         i_bg_addr,
    output logic [ADDR_W-1:0]         o_rom_addr,
    input  logic [RGB_W-1:0]          i_rom_data,
    output logic [3:0]                o_vga_r,
    output logic [3:0]                o_vga_g,
    output logic [3:0]                o_vga_b,
    output logic                      o_hsync,
    output logic                      o_vsync,
    output logic                      o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_FETCH     = 2'd1,
        S_CHECK_OBJ = 2'd2,
        S_CHECK_BG  = 2'd3
    } state_t;

    // One extra bit so the depth limit compares without truncation
    localparam logic [ADDR_W:0] c_ROM_LIMIT = ROM_DEPTH[ADDR_W:0];

`ifdef SPRITE_COLOR_KEY_EN
    localparam logic c_USE_KEY = 1'b1;
`else
    localparam logic c_USE_KEY = 1'b0;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_valid_l;
    logic              r_hs_l;
    logic              r_vs_l;
    logic              r_hit_any_l;
    logic [ADDR_W-1:0] r_obj_addr_l;
    logic [ADDR_W-1:0] r_bg_addr_l;
    logic [RGB_W-1:0]  r_pix_nxt;
    logic [RGB_W-1:0]  r_rgb;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_overrun;

    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_hit_any;
    logic [ADDR_W-1:0] w_obj_addr_clamp;
    logic [ADDR_W-1:0] w_bg_addr_clamp;
    logic              w_key_hit;
    logic              w_pix_load;
    logic [ADDR_W-1:0] w_rom_addr;

    // Priority select: scan from lowest priority up so index 0 overrides all
    always_comb begin
        w_sel_addr = '0;
        w_hit_any  = 1'b0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (i_obj_hit[i]) begin
                w_sel_addr = i_obj_addr[i*ADDR_W +: ADDR_W];
                w_hit_any  = 1'b1;
            end
        end
    end

    // Out-of-range addresses are replaced by 0 before they are latched
    assign w_obj_addr_clamp = ({1'b0, w_sel_addr} >= c_ROM_LIMIT) ? '0 : w_sel_addr;
    assign w_bg_addr_clamp  = ({1'b0, i_bg_addr}  >= c_ROM_LIMIT) ? '0 : i_bg_addr;

    // Colour key compare is common; the build option decides whether it matters
    assign w_key_hit = c_USE_KEY & (i_rom_data == TRANSPARENT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, ROM address and pixel-load decode; a new strobe always wins
    always_comb begin
        w_state_nxt = r_state;
        w_rom_addr  = '0;
        w_pix_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            S_FETCH: begin
                w_rom_addr  = r_hit_any_l ? r_obj_addr_l : r_bg_addr_l;
                w_state_nxt = S_CHECK_OBJ;
            end
            S_CHECK_OBJ: begin
                if (!r_hit_any_l || !w_key_hit) begin
                    w_pix_load  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_rom_addr  = r_bg_addr_l;
                    w_state_nxt = S_CHECK_BG;
                end
            end
            S_CHECK_BG: begin
                w_pix_load  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (i_pix_en) begin
            w_pix_load  = 1'b0;
            w_state_nxt = S_FETCH;
        end
    end

    assign o_rom_addr = w_rom_addr;

    // Pixel latches, one-pixel-delayed outputs and sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_l    <= 1'b0;
            r_hs_l       <= 1'b1;
            r_vs_l       <= 1'b1;
            r_hit_any_l  <= 1'b0;
            r_obj_addr_l <= '0;
            r_bg_addr_l  <= '0;
            r_pix_nxt    <= '0;
            r_rgb        <= '0;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_overrun    <= 1'b0;
        end else if (i_pix_en) begin
            r_rgb        <= r_pix_nxt;
            r_hsync      <= r_hs_l;
            r_vsync      <= r_vs_l;
            r_valid_l    <= i_valid;
            r_hs_l       <= i_hsync;
            r_vs_l       <= i_vsync;
            r_hit_any_l  <= w_hit_any;
            r_obj_addr_l <= w_obj_addr_clamp;
            r_bg_addr_l  <= w_bg_addr_clamp;
            if (r_state != S_IDLE) begin
                r_overrun <= 1'b1;
            end
        end else if (w_pix_load) begin
            r_pix_nxt <= r_valid_l ? i_rom_data : '0;
        end
    end

    assign o_vga_r   = r_rgb[RGB_W-1 -: 4];
    assign o_vga_g   = r_rgb[RGB_W-5 -: 4];
    assign o_vga_b   = r_rgb[RGB_W-9 -: 4];
    assign o_hsync   = r_hsync;
    assign o_vsync   = r_vsync;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire
